// File: rtl/rr_arbiter16.sv
// Round-robin arbiter for 16 requesters with hold timer, registered index/enable
// and one-hot grant outputs; a release always leaves one idle cycle before the next grant.
module rr_arbiter16 #(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CNT_W    = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] req,
    input  logic        done,
    output logic [3:0]  gnt_idx,
    output logic        gnt_en,
    output logic [15:0] gnt,
    output logic        timeout,
    output logic        busy
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST =
        CNT_W'((MAX_HOLD == 0) ? 32'd0 : MAX_HOLD - 32'd1);

    state_t            state, state_nx;
    logic [3:0]        ptr, ptr_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic [3:0]        idx_nx;
    logic              en_nx, to_nx;
    logic [15:0]       gnt_nx;
    logic [3:0]        pick;
    logic              found;
    logic              release_now;

    // First requester at or after ptr, wrapping through 15 back to ptr-1
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (!found && req[ptr + 4'(i)]) begin
                pick  = ptr + 4'(i);
                found = 1'b1;
            end
        end
    end

    assign release_now = done || !req[gnt_idx] || ((MAX_HOLD != 0) && (cnt == HOLD_LAST));

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        cnt_nx   = cnt;
        idx_nx   = gnt_idx;
        en_nx    = gnt_en;
        gnt_nx   = gnt;
        to_nx    = 1'b0;
        case (state)
            IDLE: begin
                en_nx  = 1'b0;
                gnt_nx = '0;
                if (found) begin
                    state_nx = GRANT;
                    idx_nx   = pick;
                    en_nx    = 1'b1;
                    gnt_nx   = 16'd1 << pick;
                    cnt_nx   = '0;
                end
            end
            GRANT: begin
                if (release_now) begin
                    state_nx = IDLE;
                    en_nx    = 1'b0;
                    gnt_nx   = '0;
                    ptr_nx   = gnt_idx + 4'd1;
                    cnt_nx   = '0;
                    // Timer release only when neither done nor request drop applied
                    to_nx    = !done && req[gnt_idx];
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= '0;
            cnt     <= '0;
            gnt_idx <= '0;
            gnt_en  <= 1'b0;
            gnt     <= '0;
            timeout <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nx;
            ptr     <= ptr_nx;
            cnt     <= cnt_nx;
            gnt_idx <= idx_nx;
            gnt_en  <= en_nx;
            gnt     <= gnt_nx;
            timeout <= to_nx;
            busy    <= en_nx;
        end
    end

endmodule
